// File: rtl/pio_edge_debounce.sv
// Avalon-MM parallel input port with synchroniser, per-bit debounce filter and
// rise/fall edge capture (write-1-to-clear) driving a level interrupt.
module pio_edge_debounce #(
    parameter int          WIDTH       = 10,
    parameter int          SYNC_STAGES = 2,
    parameter int          CNT_W       = 16,
    parameter int unsigned DEB_RESET   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  synced;
    logic [WIDTH-1:0][CNT_W-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]                  stable_q, stable_d;
    logic [WIDTH-1:0]                  rise_en_q, rise_en_d;
    logic [WIDTH-1:0]                  fall_en_q, fall_en_d;
    logic [WIDTH-1:0]                  mask_q, mask_d;
    logic [WIDTH-1:0]                  edge_q, edge_d;
    logic [CNT_W-1:0]                  deb_q, deb_d;
    logic [31:0]                       rd_d;
    logic [WIDTH-1:0]                  wdata_w;
    logic [WIDTH-1:0]                  clr;
    logic                              wr;
    logic                              unused_wdata;

    assign wr           = chipselect & ~write_n;
    assign wdata_w      = writedata[WIDTH-1:0];
    assign synced       = sync_q[SYNC_STAGES-1];
    assign unused_wdata = ^writedata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
        end
    end

    // The counter is cleared whenever it reaches the threshold, so it never wraps.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (synced[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] >= deb_q) begin
                stable_d[i] = synced[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_comb begin
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        mask_d    = mask_q;
        deb_d     = deb_q;
        clr       = '0;
        if (wr) begin
            case (address)
                3'd1:    rise_en_d = wdata_w;
                3'd2:    mask_d    = wdata_w;
                3'd3:    clr       = wdata_w;
                3'd4:    fall_en_d = wdata_w;
                3'd5:    deb_d     = writedata[CNT_W-1:0];
                default: ;
            endcase
        end
        // New edges are OR-ed in after the clear so a coincident event survives.
        edge_d = (edge_q & ~clr)
               | (stable_d & ~stable_q & rise_en_q)
               | (~stable_d & stable_q & fall_en_q);
    end

    always_comb begin
        rd_d = '0;
        case (address)
            3'd0:    rd_d = 32'(stable_q);
            3'd1:    rd_d = 32'(rise_en_q);
            3'd2:    rd_d = 32'(mask_q);
            3'd3:    rd_d = 32'(edge_q);
            3'd4:    rd_d = 32'(fall_en_q);
            3'd5:    rd_d = 32'(deb_q);
            default: rd_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            stable_q  <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            mask_q    <= '0;
            edge_q    <= '0;
            deb_q     <= CNT_W'(DEB_RESET);
            readdata  <= '0;
        end else begin
            cnt_q     <= cnt_d;
            stable_q  <= stable_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            mask_q    <= mask_d;
            edge_q    <= edge_d;
            deb_q     <= deb_d;
            readdata  <= rd_d;
        end
    end

    assign irq = |(edge_q & mask_q);

endmodule

// File: tb/tb_pio_edge_debounce.sv
// Directed bench for pio_edge_debounce: stimulus pushes expected read/irq values
// into queues that a negedge monitor pops and compares.
module tb_pio_edge_debounce;

    localparam int WIDTH = 10;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } expT;

    logic             clk = 1'b0;
    logic             reset;
    logic [2:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [31:0]      writedata;
    logic [31:0]      readdata;
    logic [WIDTH-1:0] in_port;
    logic             irq;

    logic rdReq, rdValid, irqChk;
    expT  rdQ[$];
    expT  irqQ[$];
    int   checks   = 0;
    int   failures = 0;

    pio_edge_debounce #(
        .WIDTH(WIDTH), .SYNC_STAGES(2), .CNT_W(16), .DEB_RESET(32'h25)
    ) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .in_port(in_port), .irq(irq)
    );

    always #5 clk = ~clk;

    // readdata is registered, so a read request becomes valid one edge later.
    always @(posedge clk) rdValid <= rdReq;

    always @(negedge clk) begin
        expT e;
        if (rdValid) begin
            checks++;
            if (rdQ.size() == 0) begin
                failures++;
                $display("[TB] FAIL rd_underflow: got %h, expected a queued entry", readdata);
            end else begin
                e = rdQ.pop_front();
                if (readdata !== e.exp) begin
                    failures++;
                    $display("[TB] FAIL %s: got %h, expected %h", e.name, readdata, e.exp);
                end
            end
        end
        if (irqChk) begin
            checks++;
            if (irqQ.size() == 0) begin
                failures++;
                $display("[TB] FAIL irq_underflow: got %b, expected a queued entry", irq);
            end else begin
                e = irqQ.pop_front();
                if (irq !== e.exp[0]) begin
                    failures++;
                    $display("[TB] FAIL %s: got %b, expected %b", e.name, irq, e.exp[0]);
                end
            end
        end
    end

    // All tasks start and end 1 ns after a rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [WIDTH-1:0] v);
        in_port = v;
    endtask

    task automatic writeReg(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic checkOutput(input logic [2:0] a, input logic [31:0] exp, input string name);
        expT e;
        e.name  = name;
        e.exp   = exp;
        rdQ.push_back(e);
        address = a;
        rdReq   = 1'b1;
        tick(1);
        rdReq   = 1'b0;
    endtask

    task automatic checkIrq(input logic exp, input string name);
        expT e;
        e.name = name;
        e.exp  = {31'b0, exp};
        irqQ.push_back(e);
        irqChk = 1'b1;
        @(negedge clk);
        #1 irqChk = 1'b0;
        tick(1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1;
        writedata = '0; in_port = '0; rdReq = 1'b0; irqChk = 1'b0;
        tick(3);
        reset = 1'b0;

        // Load non-reset state, start a count, then reset in the middle of it
        writeReg(1, 32'h3FF);
        writeReg(2, 32'h3FF);
        writeReg(4, 32'h3FF);
        writeReg(5, 32'd20);
        applyStimulus(10'h001);
        tick(5);
        #2 reset = 1'b1;
        checkIrq(1'b0, "irq_in_reset");
        checkOutput(3'd5, 32'h0, "rd_in_reset");
        #2 reset = 1'b0;
        tick(1);
        for (int a = 0; a < 8; a++)
            checkOutput(3'(a), (a == 5) ? 32'h25 : 32'h0, $sformatf("rst_reg%0d", a));
        checkIrq(1'b0, "rst_irq");

        // Input held through reset: stable follows after DEB_RESET, nothing captured
        tick(45);
        checkOutput(3'd0, 32'h001, "held_data");
        checkOutput(3'd3, 32'h000, "held_nocap");

        writeReg(5, 32'd0);
        applyStimulus(10'h000);
        tick(4);
        writeReg(0, 32'h3FF);
        writeReg(6, 32'hFFFF_FFFF);
        checkOutput(3'd0, 32'h000, "data_ro");
        checkOutput(3'd6, 32'h000, "addr6_zero");
        checkOutput(3'd7, 32'h000, "addr7_zero");

        // Bypass: change sampled at e+1 lands in stable/capture at e+3
        writeReg(1, 32'h3FF);
        writeReg(2, 32'h3FF);
        checkOutput(3'd2, 32'h3FF, "mask_rb");
        applyStimulus(10'h001);
        tick(2);
        checkIrq(1'b0, "byp_irq_before");
        checkIrq(1'b1, "byp_irq_edge2");
        checkOutput(3'd3, 32'h001, "byp_cap");
        checkOutput(3'd0, 32'h001, "byp_data");
        writeReg(3, 32'h001);
        checkIrq(1'b0, "byp_irq_w1c");
        checkOutput(3'd3, 32'h000, "byp_cap_clr");
        applyStimulus(10'h000);
        tick(4);

        // Debounce N=5: 4-clock glitch rejected, held level accepted at e+8
        writeReg(5, 32'd5);
        applyStimulus(10'h008);
        tick(4);
        applyStimulus(10'h000);
        tick(8);
        checkOutput(3'd0, 32'h000, "glitch_data");
        checkOutput(3'd3, 32'h000, "glitch_cap");
        checkIrq(1'b0, "glitch_irq");
        applyStimulus(10'h008);
        tick(7);
        checkOutput(3'd0, 32'h000, "deb_pre");
        checkOutput(3'd0, 32'h008, "deb_edge7");
        checkIrq(1'b1, "deb_irq");
        checkOutput(3'd3, 32'h008, "deb_cap");
        applyStimulus(10'h000);
        tick(10);
        writeReg(3, 32'h008);
        checkOutput(3'd3, 32'h000, "deb_w1c");

        // Edge select: falling only, masked interrupt
        writeReg(1, 32'h000);
        writeReg(4, 32'h010);
        writeReg(2, 32'h000);
        writeReg(5, 32'd0);
        applyStimulus(10'h010);
        tick(4);
        checkOutput(3'd0, 32'h010, "esel_data");
        checkOutput(3'd3, 32'h000, "esel_rise_none");
        applyStimulus(10'h000);
        tick(4);
        checkOutput(3'd3, 32'h010, "esel_fall");
        checkIrq(1'b0, "esel_irq_masked");
        writeReg(3, 32'h010);

        // New edge on bit 1 coincides with a W1C of bits 0 and 1
        writeReg(1, 32'h3FF);
        writeReg(4, 32'h002);
        writeReg(2, 32'h3FF);
        applyStimulus(10'h003);
        tick(4);
        checkOutput(3'd3, 32'h003, "sim_pre");
        checkIrq(1'b1, "sim_irq_pre");
        applyStimulus(10'h001);
        tick(2);
        writeReg(3, 32'h003);
        checkIrq(1'b1, "sim_irq");
        checkOutput(3'd3, 32'h002, "sim_cap");
        writeReg(3, 32'h3FF);
        checkIrq(1'b0, "sim_irq_clr");

        // Threshold lowered from 20 to 3 while cnt is 7
        writeReg(5, 32'd20);
        applyStimulus(10'h005);
        tick(9);
        writeReg(5, 32'd3);
        checkOutput(3'd0, 32'h001, "dbw_before");
        checkOutput(3'd0, 32'h005, "dbw_after");
        checkOutput(3'd3, 32'h004, "dbw_cap");
        checkOutput(3'd5, 32'h003, "dbw_rb");

        tick(3);
        checks++;
        if (rdQ.size() != 0 || irqQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL queue_drain: got %0d/%0d pending, expected 0/0",
                     rdQ.size(), irqQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
